// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and constants, also used by decoder-side pipeline control.
// Holds the FSM encoding, the NOP word and the PC step.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port, decoder handoff and redirect input.
// master = fetch stage, slave = memory/decoder environment.
interface instr_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] prog;
    logic [31:0] pc_out;
    logic        prog_valid;
    logic        prog_ready;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, prog, pc_out, prog_valid, fetch_err,
        input  imem_rvalid, imem_rdata, prog_ready, jmp_en, jmp_addr
    );

    modport slave (
        input  imem_req, imem_addr, prog, pc_out, prog_valid, fetch_err,
        output imem_rvalid, imem_rdata, prog_ready, jmp_en, jmp_addr
    );

endinterface

// File: rtl/instr_fetch_timer.sv
// Response watchdog: counts enabled cycles since clear, flags expiry on the TIMEOUT-th cycle.
// Expiry is combinational from the count; no backpressure, saturates once expired.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, one outstanding imem read, presents prog with valid/ready.
// prog_valid one cycle after imem_rvalid (3 cycles/instr min); holds in VALID while prog_ready=0.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master fetch_bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  prog_q, prog_d;
    logic [31:0]  pc_out_q, pc_out_d;
    logic         prog_valid_q, prog_valid_d;
    logic         drop_q, drop_d;
    logic         err_q, err_d;
    logic         run_q;
    logic         issue;
    logic         timer_expired;

    // run_q keeps the reset-state ISSUE from requesting until the first edge after reset.
    assign issue = (state_q == ST_ISSUE) && run_q;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        prog_d       = prog_q;
        pc_out_d     = pc_out_q;
        prog_valid_d = prog_valid_q;
        drop_d       = drop_q;
        err_d        = err_q;

        unique case (state_q)
            ST_ISSUE: begin
                if (run_q) begin
                    state_d = ST_WAIT;
                    if (fetch_bus.jmp_en) begin
                        drop_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (fetch_bus.imem_rvalid) begin
                    if (drop_q || fetch_bus.jmp_en) begin
                        drop_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        prog_d       = fetch_bus.imem_rdata;
                        pc_out_d     = pc_q;
                        pc_d         = pc_q + PC_INC;
                        prog_valid_d = 1'b1;
                        state_d      = ST_VALID;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else if (fetch_bus.jmp_en) begin
                    drop_d = 1'b1;
                end
            end
            ST_VALID: begin
                // A redirect retires the presented word whether or not it was taken.
                if (fetch_bus.jmp_en || fetch_bus.prog_ready) begin
                    prog_valid_d = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_HALT: begin
                prog_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (fetch_bus.jmp_en && (state_q != ST_HALT)) begin
            pc_d = word_align(fetch_bus.jmp_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ISSUE;
            pc_q         <= word_align(RESET_PC);
            prog_q       <= NOP_INSTR;
            pc_out_q     <= '0;
            prog_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            prog_q       <= prog_d;
            pc_out_q     <= pc_out_d;
            prog_valid_q <= prog_valid_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
            run_q        <= 1'b1;
        end
    end

    assign fetch_bus.imem_req   = issue;
    assign fetch_bus.imem_addr  = issue ? pc_q : 32'h0;
    assign fetch_bus.prog       = prog_q;
    assign fetch_bus.pc_out     = pc_out_q;
    assign fetch_bus.prog_valid = prog_valid_q;
    assign fetch_bus.fetch_err  = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic clk;
    logic rst_n;

    instr_fetch_if if0 ();
    instr_fetch_if if1 ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .fetch_bus(if0)
    );
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_bus(if1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr[$];
    exp_t        exp_prog[$];

    int mem_lat = 1;
    bit mem_on  = 1'b1;

    int          n1 = 0;
    logic [31:0] exp1_pc[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {a[15:0], 16'h0013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait until all expected requests have been seen and dut0 is parked in VALID.
    task automatic wait_parked(input string name);
        int n = 0;
        while (!(exp_addr.size() == 0 && if0.prog_valid === 1'b1) && n < 200) begin
            step(1);
            n++;
        end
        n_tests++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL %s: got no parked VALID within %0d cycles, required parked", name, n);
        end
    endtask

    // Instruction memory for dut0: configurable latency, can be silenced.
    initial begin
        logic        r;
        logic [31:0] a;
        logic [31:0] baddr;
        bit          busy;
        int          cnt;
        busy = 1'b0;
        cnt  = 0;
        baddr = '0;
        if0.imem_rvalid = 1'b0;
        if0.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            r = if0.imem_req;
            a = if0.imem_addr;
            @(posedge clk);
            #1;
            if0.imem_rvalid = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    if0.imem_rvalid = 1'b1;
                    if0.imem_rdata  = word(baddr);
                    busy = 1'b0;
                end
            end else if (r && mem_on) begin
                if (mem_lat <= 1) begin
                    if0.imem_rvalid = 1'b1;
                    if0.imem_rdata  = word(a);
                end else begin
                    busy  = 1'b1;
                    cnt   = mem_lat - 1;
                    baddr = a;
                end
            end
        end
    end

    // Instruction memory and always-ready consumer for dut1.
    initial begin
        logic        r;
        logic [31:0] a;
        if1.imem_rvalid = 1'b0;
        if1.imem_rdata  = '0;
        if1.prog_ready  = 1'b1;
        if1.jmp_en      = 1'b0;
        if1.jmp_addr    = '0;
        forever begin
            @(negedge clk);
            r = if1.imem_req;
            a = if1.imem_addr;
            @(posedge clk);
            #1;
            if1.imem_rvalid = r;
            if1.imem_rdata  = r ? word(a) : 32'h0;
        end
    end

    // dut0 scoreboard monitor: requests and accepted instructions.
    initial begin
        logic [31:0] a;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if0.imem_req) begin
                    if (exp_addr.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_req: got req addr %h, required no request", if0.imem_addr);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("imem_addr", if0.imem_addr, a);
                    end
                end
                if (if0.prog_valid && if0.prog_ready) begin
                    if (exp_prog.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_prog: got %h at %h, required none", if0.prog, if0.pc_out);
                    end else begin
                        e = exp_prog.pop_front();
                        chk("pc_out", if0.pc_out, e.pc);
                        chk("prog", if0.prog, e.ins);
                    end
                end
            end
        end
    end

    // dut1 monitor: first two presented instructions across the PC wrap.
    initial begin
        exp1_pc[0] = 32'hFFFF_FFFC;
        exp1_pc[1] = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (rst_n && if1.prog_valid && n1 < 2) begin
                chk("wrap_pc_out", if1.pc_out, exp1_pc[n1]);
                chk("wrap_prog", if1.prog, word(exp1_pc[n1]));
                n1++;
            end
        end
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        if0.prog_ready = 1'b0;
        if0.jmp_en     = 1'b0;
        if0.jmp_addr   = '0;
        step(3);

        // Reset state
        chk("rst_imem_req", {31'h0, if0.imem_req}, 32'h0);
        chk("rst_imem_addr", if0.imem_addr, 32'h0);
        chk("rst_prog", if0.prog, 32'h0000_0013);
        chk("rst_pc_out", if0.pc_out, 32'h0);
        chk("rst_prog_valid", {31'h0, if0.prog_valid}, 32'h0);
        chk("rst_fetch_err", {31'h0, if0.fetch_err}, 32'h0);

        // 1: first fetch from address 0 with 1-cycle memory
        exp_addr.push_back(32'h0);
        exp_prog.push_back('{pc: 32'h0, ins: 32'h0050_0093});
        rst_n = 1'b1;
        cyc = 0;
        do begin
            step(1);
            cyc++;
            if (cyc == 1) begin
                chk("t1_req_cycle1", {31'h0, if0.imem_req}, 32'h1);
                chk("t1_addr_cycle1", if0.imem_addr, 32'h0);
            end
        end while (if0.prog_valid !== 1'b1 && cyc < 20);
        chk("t1_valid_latency", cyc, 3);
        chk("t1_prog", if0.prog, 32'h0050_0093);

        // 2: stall in VALID for 5 cycles, then accept
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t2_stable_prog", if0.prog, 32'h0050_0093);
            chk("t2_stable_pc", if0.pc_out, 32'h0);
            chk("t2_stable_valid", {31'h0, if0.prog_valid}, 32'h1);
        end
        exp_addr.push_back(32'h4);
        exp_prog.push_back('{pc: 32'h4, ins: word(32'h4)});
        if0.prog_ready = 1'b1;
        step(1);
        if0.prog_ready = 1'b0;
        wait_parked("t2_park");
        chk("t2_next_pc", if0.pc_out, 32'h4);

        // 3: redirect during WAIT with 3-cycle memory drops the in-flight word
        mem_lat = 3;
        exp_addr.push_back(32'h8);
        if0.prog_ready = 1'b1;
        step(1);
        if0.prog_ready = 1'b0;
        step(1);
        if0.jmp_en   = 1'b1;
        if0.jmp_addr = 32'h0000_0103;
        step(1);
        if0.jmp_en   = 1'b0;
        exp_addr.push_back(32'h100);
        exp_prog.push_back('{pc: 32'h100, ins: word(32'h100)});
        wait_parked("t3_park");
        chk("t3_pc_out", if0.pc_out, 32'h100);
        chk("t3_prog", if0.prog, word(32'h100));

        // 4: jump and ready together in VALID -> one redirect to 0x40
        mem_lat = 1;
        exp_addr.push_back(32'h40);
        exp_prog.push_back('{pc: 32'h40, ins: word(32'h40)});
        if0.prog_ready = 1'b1;
        if0.jmp_en     = 1'b1;
        if0.jmp_addr   = 32'h40;
        step(1);
        if0.prog_ready = 1'b0;
        if0.jmp_en     = 1'b0;
        wait_parked("t4_park");
        chk("t4_pc_out", if0.pc_out, 32'h40);

        // 5: memory silent -> fetch_err after 16 WAIT cycles, cleared by async reset
        mem_on = 1'b0;
        exp_addr.push_back(32'h44);
        if0.prog_ready = 1'b1;
        step(1);
        if0.prog_ready = 1'b0;
        step(16);
        chk("t5_err_before", {31'h0, if0.fetch_err}, 32'h0);
        step(1);
        chk("t5_err_after", {31'h0, if0.fetch_err}, 32'h1);
        step(20);
        chk("t5_halt_err_sticky", {31'h0, if0.fetch_err}, 32'h1);
        chk("t5_halt_valid", {31'h0, if0.prog_valid}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_async_err_clear", {31'h0, if0.fetch_err}, 32'h0);
        chk("t5_async_req", {31'h0, if0.imem_req}, 32'h0);
        mem_on = 1'b1;
        step(2);
        exp_addr.push_back(32'h0);
        rst_n = 1'b1;
        wait_parked("t5_restart");
        chk("t5_restart_pc", if0.pc_out, 32'h0);
        chk("t5_restart_prog", if0.prog, 32'h0050_0093);

        // 6: dut1 wrap results, and nothing left outstanding in the scoreboard
        step(10);
        chk("t6_wrap_count", n1, 2);
        chk("sb_addr_left", exp_addr.size(), 0);
        chk("sb_prog_left", exp_prog.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
